// File: rtl/axis_hdr_insert_sched.sv
// axis_hdr_insert_sched
// Packet-granular round-robin scheduler that lets NUM_SRC requesters share one
// header inserter. A requester is granted on its header request, its header is
// presented to the inserter, then its payload is passed through combinationally
// until the last beat, after which the grant is released.
module axis_hdr_insert_sched #(
    parameter int NUM_SRC      = 4,
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int SRC_WD       = $clog2(NUM_SRC)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    // payload from requesters
    input  logic [NUM_SRC-1:0]              s_valid,
    input  logic [NUM_SRC-1:0]              s_last,
    input  logic [NUM_SRC*DATA_WD-1:0]      s_data,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep,
    output logic [NUM_SRC-1:0]              s_ready,
    // header requests
    input  logic [NUM_SRC-1:0]              h_valid,
    input  logic [NUM_SRC*DATA_WD-1:0]      h_data,
    input  logic [NUM_SRC*BYTE_CNT_WD-1:0]  h_cnt,
    output logic [NUM_SRC-1:0]              h_ready,
    // payload to inserter
    output logic                            valid_in,
    output logic [DATA_WD-1:0]              data_in,
    output logic [DATA_BYTE_WD-1:0]         keep_in,
    output logic                            last_in,
    input  logic                            ready_in,
    // header to inserter
    output logic                            valid_insert,
    output logic [DATA_WD-1:0]              data_insert,
    output logic [DATA_BYTE_WD-1:0]         keep_insert,
    output logic [BYTE_CNT_WD-1:0]          byte_insert_cnt,
    input  logic                            ready_insert,
    // status
    output logic                            busy,
    output logic [SRC_WD-1:0]               cur_src,
    output logic                            pkt_done,
    output logic [15:0]                     pkt_len
);

    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA} state_t;

    localparam logic [SRC_WD:0]   NSRC     = (SRC_WD+1)'(NUM_SRC);
    localparam logic [SRC_WD-1:0] LAST_SRC = SRC_WD'(NUM_SRC - 1);

    state_t            state_q, state_d;
    logic [SRC_WD-1:0] cur_src_q, cur_src_d;
    logic [SRC_WD-1:0] rr_q, rr_d;
    logic [15:0]       beat_cnt_q, beat_cnt_d;
    logic [15:0]       pkt_len_q, pkt_len_d;
    logic              pkt_done_q, pkt_done_d;

    logic [DATA_WD-1:0]      h_data_arr [NUM_SRC];
    logic [BYTE_CNT_WD-1:0]  h_cnt_arr  [NUM_SRC];
    logic [DATA_WD-1:0]      s_data_arr [NUM_SRC];
    logic [DATA_BYTE_WD-1:0] s_keep_arr [NUM_SRC];

    logic [SRC_WD-1:0] winner;
    logic              found;
    logic [15:0]       beat_inc;
    logic              beat_hs;

    // Unpack the flat per-requester buses into arrays indexed by requester
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_slice
            assign h_data_arr[gi] = h_data[gi*DATA_WD +: DATA_WD];
            assign h_cnt_arr[gi]  = h_cnt[gi*BYTE_CNT_WD +: BYTE_CNT_WD];
            assign s_data_arr[gi] = s_data[gi*DATA_WD +: DATA_WD];
            assign s_keep_arr[gi] = s_keep[gi*DATA_BYTE_WD +: DATA_BYTE_WD];
        end
    endgenerate

    // Header keep mask: byte b is valid when b <= byte count
    generate
        for (genvar gi = 0; gi < DATA_BYTE_WD; gi++) begin : g_keep
            assign keep_insert[gi] = ((BYTE_CNT_WD+1)'(gi) <= {1'b0, byte_insert_cnt});
        end
    endgenerate

    // Header and payload muxes from the granted requester
    assign valid_insert    = (state_q == ST_HDR);
    assign data_insert     = h_data_arr[cur_src_q];
    assign byte_insert_cnt = h_cnt_arr[cur_src_q];
    assign valid_in        = (state_q == ST_DATA) && s_valid[cur_src_q];
    assign last_in         = (state_q == ST_DATA) && s_last[cur_src_q];
    assign data_in         = s_data_arr[cur_src_q];
    assign keep_in         = s_keep_arr[cur_src_q];
    assign busy            = (state_q != ST_IDLE);
    assign cur_src         = cur_src_q;
    assign pkt_done        = pkt_done_q;
    assign pkt_len         = pkt_len_q;
    assign beat_hs         = valid_in && ready_in;
    assign beat_inc        = (beat_cnt_q == 16'hFFFF) ? beat_cnt_q : beat_cnt_q + 16'd1;

    // Ready fan-out: only the granted requester ever sees a ready
    always_comb begin
        h_ready = '0;
        s_ready = '0;
        if (state_q == ST_HDR)  h_ready[cur_src_q] = ready_insert;
        if (state_q == ST_DATA) s_ready[cur_src_q] = ready_in;
    end

    // Round-robin search: first requesting index starting from rr
    always_comb begin
        logic [SRC_WD:0] idx_w;
        winner = '0;
        found  = 1'b0;
        idx_w  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx_w = {1'b0, rr_q} + (SRC_WD+1)'(k);
            if (idx_w >= NSRC) idx_w = idx_w - NSRC;
            if (!found && h_valid[idx_w[SRC_WD-1:0]]) begin
                found  = 1'b1;
                winner = idx_w[SRC_WD-1:0];
            end
        end
    end

    // Next-state logic: grant, header handshake, payload until last
    always_comb begin
        state_d    = state_q;
        cur_src_d  = cur_src_q;
        rr_d       = rr_q;
        beat_cnt_d = beat_cnt_q;
        pkt_len_d  = pkt_len_q;
        pkt_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    cur_src_d = winner;
                    state_d   = ST_HDR;
                end
            end
            ST_HDR: begin
                if (ready_insert) begin
                    state_d    = ST_DATA;
                    beat_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (beat_hs) begin
                    beat_cnt_d = beat_inc;
                    if (last_in) begin
                        state_d    = ST_IDLE;
                        rr_d       = (cur_src_q == LAST_SRC) ? '0 : cur_src_q + 1'b1;
                        pkt_len_d  = beat_inc;
                        pkt_done_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cur_src_q  <= '0;
            rr_q       <= '0;
            beat_cnt_q <= '0;
            pkt_len_q  <= '0;
            pkt_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_src_q  <= cur_src_d;
            rr_q       <= rr_d;
            beat_cnt_q <= beat_cnt_d;
            pkt_len_q  <= pkt_len_d;
            pkt_done_q <= pkt_done_d;
        end
    end

endmodule

// File: tb/tb_axis_hdr_insert_sched.sv
// Randomized scoreboard bench for axis_hdr_insert_sched (4 requesters, 32-bit).
module tb_axis_hdr_insert_sched;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      s_valid, s_last, s_ready, h_valid, h_ready;
    logic [N*32-1:0]   s_data, h_data;
    logic [N*4-1:0]    s_keep;
    logic [N*2-1:0]    h_cnt;
    logic              valid_in, last_in, ready_in;
    logic [31:0]       data_in, data_insert;
    logic [3:0]        keep_in, keep_insert;
    logic              valid_insert, ready_insert;
    logic [1:0]        byte_insert_cnt, cur_src;
    logic              busy, pkt_done;
    logic [15:0]       pkt_len;

    axis_hdr_insert_sched dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_last(s_last), .s_data(s_data), .s_keep(s_keep), .s_ready(s_ready),
        .h_valid(h_valid), .h_data(h_data), .h_cnt(h_cnt), .h_ready(h_ready),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
        .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
        .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert),
        .busy(busy), .cur_src(cur_src), .pkt_done(pkt_done), .pkt_len(pkt_len)
    );

    always #5 clk = ~clk;

    typedef struct {int src; logic [31:0] data; logic [1:0] cnt;} hdr_t;
    typedef struct {logic [31:0] data; logic [3:0] keep; logic last;} beat_t;

    hdr_t  exp_hdr_q[$];
    beat_t exp_beat_q[$];
    int    exp_len_q[$];

    int n_vec = 0;
    int n_miss = 0;
    bit drv_done = 0;
    bit drv_timeout = 0;

    // requester-side packet storage
    logic [31:0] pk_data [N][8];
    logic [3:0]  pk_keep [N][8];
    int          nbeats [N];
    int          bidx [N];
    bit          pend [N];
    int          rr_m = 0;
    int          hold_ri = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic bit any_pend();
        bit r = 0;
        for (int i = 0; i < N; i++) r |= pend[i];
        return r;
    endfunction

    // Load one packet onto requester i and push its expected transactions
    task automatic load_pkt(input int i, input int lo, input int hi, input bit fixed);
        int n;
        hdr_t h;
        beat_t b;
        n = int'($urandom_range(hi, lo));
        h.src  = i;
        h.data = fixed ? 32'hAABBCCDD : $urandom;
        h.cnt  = fixed ? 2'd1 : 2'($urandom_range(3, 0));
        if (fixed) n = 3;
        h_valid[i] = 1'b1;
        h_data[i*32 +: 32] = h.data;
        h_cnt[i*2 +: 2] = h.cnt;
        pend[i] = 1; bidx[i] = 0; nbeats[i] = n;
        exp_hdr_q.push_back(h);
        for (int k = 0; k < n; k++) begin
            pk_data[i][k] = $urandom;
            pk_keep[i][k] = 4'($urandom_range(15, 1));
            b.data = pk_data[i][k];
            b.keep = pk_keep[i][k];
            b.last = (k == n - 1);
            exp_beat_q.push_back(b);
        end
        exp_len_q.push_back(n);
    endtask

    // Reference arbitration: requesters requesting together are served in
    // rotational order starting at the pointer; pointer moves past the last one
    task automatic start_round(input logic [3:0] sub, input int lo, input int hi, input bit fixed);
        int last_i = 0;
        for (int k = 0; k < N; k++) begin
            int i = (rr_m + k) % N;
            if (sub[i]) begin
                load_pkt(i, lo, hi, fixed);
                last_i = i;
            end
        end
        rr_m = (last_i + 1) % N;
    endtask

    // One clock of requester behaviour with random gaps and backpressure
    task automatic step();
        logic [N-1:0] hs_h, hs_s;
        @(negedge clk);
        hs_h = h_valid & h_ready;
        hs_s = s_valid & s_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs_h[i]) h_valid[i] = 1'b0;
            if (hs_s[i]) begin
                s_valid[i] = 1'b0;
                s_last[i]  = 1'b0;
                bidx[i]++;
                if (bidx[i] == nbeats[i]) pend[i] = 0;
            end
            if (pend[i] && !s_valid[i] && bidx[i] < nbeats[i] && $urandom_range(3, 0) != 0) begin
                s_valid[i] = 1'b1;
                s_data[i*32 +: 32] = pk_data[i][bidx[i]];
                s_keep[i*4 +: 4] = pk_keep[i][bidx[i]];
                s_last[i] = (bidx[i] == nbeats[i] - 1);
            end
        end
        if (hold_ri > 0) begin
            ready_insert = 1'b0;
            hold_ri--;
        end else begin
            ready_insert = ($urandom_range(3, 0) != 0);
            if ($urandom_range(15, 0) == 0) hold_ri = 5;
        end
        ready_in = ($urandom_range(2, 0) != 0);
    endtask

    task automatic run_until_idle();
        int n = 0;
        while (any_pend() && n < 600) begin
            step();
            n++;
        end
        if (any_pend()) drv_timeout = 1;
    endtask

    // Stimulus
    initial begin
        s_valid = '0; s_last = '0; s_data = '0; s_keep = '0;
        h_valid = '0; h_data = '0; h_cnt = '0;
        ready_in = 1'b0; ready_insert = 1'b0;
        for (int i = 0; i < N; i++) begin pend[i] = 0; bidx[i] = 0; nbeats[i] = 0; end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int r = 0; r < 60 && !drv_timeout; r++) begin
            if (r == 0)     start_round(4'b0100, 3, 3, 1);
            else if (r < 3) start_round(4'b1111, 1, 1, 0);
            else            start_round(4'($urandom_range(15, 1)), 1, 6, 0);
            run_until_idle();
        end
        // Reset during the second payload beat of requester 3
        if (!drv_timeout) begin
            int n = 0;
            start_round(4'b1000, 4, 4, 0);
            while (!(bidx[3] == 1 && s_valid[3]) && n < 300) begin
                step();
                n++;
            end
            if (n >= 300) drv_timeout = 1;
            #2 rst_n = 1'b0;
            @(negedge clk);
            @(posedge clk);
            #1 rst_n = 1'b1;
            h_valid = '0; s_valid = '0; s_last = '0;
            for (int i = 0; i < N; i++) pend[i] = 0;
            rr_m = 0;
            start_round(4'b1111, 1, 3, 0);
            run_until_idle();
        end
        repeat (3) step();
        drv_done = 1;
    end

    // Monitor / scoreboard
    initial begin
        int    mphase = 0;   // 0 idle, 1 header offered, 2 payload
        int    msrc = 0;
        bit    exp_done = 0;
        int    cyc = 0;
        hdr_t  h;
        beat_t b;
        logic [3:0] exp_rdy;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                chk("rst_busy", busy, 0);
                chk("rst_valid_in", valid_in, 0);
                chk("rst_valid_insert", valid_insert, 0);
                chk("rst_s_ready", s_ready, 0);
                chk("rst_h_ready", h_ready, 0);
                chk("rst_pkt_done", pkt_done, 0);
                chk("rst_cur_src", cur_src, 0);
                chk("rst_pkt_len", pkt_len, 0);
                mphase = 0;
                exp_done = 0;
                exp_hdr_q.delete();
                exp_beat_q.delete();
                exp_len_q.delete();
            end else begin
                chk("pkt_done", pkt_done, exp_done);
                if (exp_done && exp_len_q.size() > 0) chk("pkt_len", pkt_len, exp_len_q.pop_front());
                exp_done = 0;
                chk("busy", busy, mphase != 0);
                chk("valid_insert", valid_insert, mphase == 1);
                case (mphase)
                    0: begin
                        chk("idle_valid_in", valid_in, 0);
                        chk("idle_last_in", last_in, 0);
                        chk("idle_h_ready", h_ready, 0);
                        chk("idle_s_ready", s_ready, 0);
                        if (h_valid != '0) begin
                            if (exp_hdr_q.size() == 0) begin
                                chk("sb_hdr_empty", exp_hdr_q.size(), 1);
                            end else begin
                                h = exp_hdr_q.pop_front();
                                msrc = h.src;
                                mphase = 1;
                            end
                        end
                    end
                    1: begin
                        exp_rdy = ready_insert ? (4'b0001 << msrc) : 4'b0000;
                        chk("hdr_cur_src", cur_src, msrc);
                        chk("data_insert", data_insert, h.data);
                        chk("byte_insert_cnt", byte_insert_cnt, h.cnt);
                        chk("keep_insert", keep_insert, (1 << (int'(h.cnt) + 1)) - 1);
                        chk("hdr_h_ready", h_ready, exp_rdy);
                        chk("hdr_s_ready", s_ready, 0);
                        chk("hdr_valid_in", valid_in, 0);
                        if (ready_insert) mphase = 2;
                    end
                    default: begin
                        exp_rdy = ready_in ? (4'b0001 << msrc) : 4'b0000;
                        chk("data_cur_src", cur_src, msrc);
                        chk("data_valid_in", valid_in, s_valid[msrc]);
                        chk("data_s_ready", s_ready, exp_rdy);
                        chk("data_h_ready", h_ready, 0);
                        if (s_valid[msrc] && ready_in) begin
                            if (exp_beat_q.size() == 0) begin
                                chk("sb_beat_empty", exp_beat_q.size(), 1);
                            end else begin
                                b = exp_beat_q.pop_front();
                                chk("data_in", data_in, b.data);
                                chk("keep_in", keep_in, b.keep);
                                chk("last_in", last_in, b.last);
                                if (b.last) begin
                                    mphase = 0;
                                    exp_done = 1;
                                end
                            end
                        end
                    end
                endcase
            end
            if (drv_done) begin
                chk("drv_timeout", drv_timeout, 0);
                chk("sb_hdr_left", exp_hdr_q.size(), 0);
                chk("sb_beat_left", exp_beat_q.size(), 0);
                chk("sb_len_left", exp_len_q.size(), 0);
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
                $finish;
            end
            if (cyc > 50000) begin
                n_miss++;
                $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
                $finish;
            end
        end
    end

endmodule
